// File: rtl/crc3_req_scheduler.sv
// Round-robin scheduler sharing one serial CRC-3 engine between NUM_REQ requesters.
// Feeds each accepted 5-bit message plus 3 zero bits, captures the codeword and cross-checks it.
module crc3_req_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [5*NUM_REQ-1:0] req_msg_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 eng_enable_o,
    output logic                 eng_data_o,
    input  logic [7:0]           eng_result_i,
    output logic                 res_valid_o,
    output logic [7:0]           res_data_o,
    output logic [ID_W-1:0]      res_id_o,
    output logic                 busy_o,
    output logic                 err_o,
    input  logic                 err_clr_i
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FEED    = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam int                SUM_W     = ID_W + 1;
    localparam logic [SUM_W-1:0]  NUM_REQ_S = SUM_W'(NUM_REQ);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

    function automatic logic [2:0] crc3_step(input logic [2:0] c, input logic b);
        crc3_step = {b ^ c[2] ^ c[0], c[2:1]};
    endfunction

    logic [1:0]           state_q, state_d;
    logic [ID_W-1:0]      rr_q, rr_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [4:0]           msg_q, msg_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [2:0]           crc_q, crc_d;
    logic                 res_valid_q, res_valid_d;
    logic [7:0]           res_data_q, res_data_d;
    logic [ID_W-1:0]      res_id_q, res_id_d;
    logic                 err_q, err_d;

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [ID_W-1:0]      off_s;
    logic                 grant_hit_s;
    logic [SUM_W-1:0]     sum_s;
    logic [SUM_W-1:0]     idx_s;
    logic [ID_W-1:0]      grant_id_s;
    logic [5*NUM_REQ-1:0] msg_shift_s;
    logic [4:0]           sel_msg_s;
    logic                 feed_bit_s;
    logic                 new_err_s;

    // Rotate valids so the search starts at rr, then take the lowest set bit
    always_comb begin
        dbl_s       = {req_valid_i, req_valid_i} >> rr_q;
        rot_s       = dbl_s[NUM_REQ-1:0];
        off_s       = '0;
        grant_hit_s = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            off_s       = rot_s[k] ? ID_W'(k) : off_s;
            grant_hit_s = grant_hit_s | rot_s[k];
        end
        sum_s       = {1'b0, rr_q} + {1'b0, off_s};
        idx_s       = (sum_s >= NUM_REQ_S) ? (sum_s - NUM_REQ_S) : sum_s;
        grant_id_s  = idx_s[ID_W-1:0];
        msg_shift_s = req_msg_i >> (5 * int'(grant_id_s));
        sel_msg_s   = msg_shift_s[4:0];
    end

    // One-hot grant, only offered while idle
    always_comb begin
        if ((state_q == ST_IDLE) && grant_hit_s) begin
            req_ready_o = NUM_REQ'(1'b1) << grant_id_s;
        end else begin
            req_ready_o = '0;
        end
    end

    // Serial bit: message MSB first for cnt 0..4, zero padding afterwards
    always_comb begin
        if ((state_q == ST_FEED) && (cnt_q < 3'd5)) begin
            feed_bit_s = msg_q[3'd4 - cnt_q];
        end else begin
            feed_bit_s = 1'b0;
        end
    end

    // Next-state logic for the job sequencer, result capture and sticky error
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        msg_d       = msg_q;
        id_d        = id_q;
        crc_d       = crc_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        new_err_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_hit_s) begin
                    state_d = ST_FEED;
                    msg_d   = sel_msg_s;
                    id_d    = grant_id_s;
                    rr_d    = (grant_id_s == LAST_ID) ? '0 : grant_id_s + ID_W'(1'b1);
                    cnt_d   = 3'd0;
                    crc_d   = 3'b000;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FEED: begin
                crc_d = crc3_step(crc_q, feed_bit_s);
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_FEED;
                end
            end
            ST_WAIT: begin
                res_data_d  = eng_result_i;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                new_err_s   = CHECK_EN && (eng_result_i != {msg_q, crc_q});
                state_d     = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A fresh mismatch outranks a same-cycle clear
        if (new_err_s) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers; reset drops any job in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            cnt_q       <= 3'd0;
            msg_q       <= 5'd0;
            id_q        <= '0;
            crc_q       <= 3'b000;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            res_id_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            msg_q       <= msg_d;
            id_q        <= id_d;
            crc_q       <= crc_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            err_q       <= err_d;
        end
    end

    assign eng_enable_o = (state_q == ST_FEED) || (state_q == ST_WAIT);
    assign eng_data_o   = feed_bit_s;
    assign busy_o       = (state_q != ST_IDLE);
    assign res_valid_o  = res_valid_q;
    assign res_data_o   = res_data_q;
    assign res_id_o     = res_id_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_crc3_req_scheduler.sv
// Scoreboard bench for crc3_req_scheduler: a cycle-level reference model predicts grants,
// engine drive and err; a monitor pops expected codewords when res_valid pulses.
module tb_crc3_req_scheduler;

    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int MW       = 5 * N;
    localparam int CLK_HALF = 5;
    localparam int PERIOD   = 2 * CLK_HALF;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [MW-1:0]  req_msg;
    logic           err_clr;
    logic [N-1:0]   ready1, ready2;
    logic           en1, en2, dat1, dat2;
    logic [7:0]     eres1, eres2;
    logic           rv1, rv2;
    logic [7:0]     rd1, rd2;
    logic [IDW-1:0] rid1, rid2;
    logic           busy1, busy2, err1, err2;
    bit             inject;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [IDW-1:0] id;
        logic [7:0]     data;
        time            due;
    } exp_t;
    exp_t sb[$];

    always #CLK_HALF clk = ~clk;

    crc3_req_scheduler #(.NUM_REQ(N), .ID_W(IDW), .CHECK_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_msg_i(req_msg),
        .req_ready_o(ready1), .eng_enable_o(en1), .eng_data_o(dat1), .eng_result_i(eres1),
        .res_valid_o(rv1), .res_data_o(rd1), .res_id_o(rid1), .busy_o(busy1),
        .err_o(err1), .err_clr_i(err_clr)
    );

    crc3_req_scheduler #(.NUM_REQ(N), .ID_W(IDW), .CHECK_EN(1'b0)) dut_nochk (
        .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_msg_i(req_msg),
        .req_ready_o(ready2), .eng_enable_o(en2), .eng_data_o(dat2), .eng_result_i(eres2),
        .res_valid_o(rv2), .res_data_o(rd2), .res_id_o(rid2), .busy_o(busy2),
        .err_o(err2), .err_clr_i(err_clr)
    );

    function automatic logic [7:0] codeword(input logic [4:0] m);
        logic [2:0] c;
        logic [7:0] bits;
        c    = 3'b000;
        bits = {m, 3'b000};
        for (int i = 7; i >= 0; i--) c = {bits[i] ^ c[2] ^ c[0], c[2:1]};
        return {m, c};
    endfunction

    function automatic logic bit_of(input logic [N-1:0] v, input int k);
        logic [N-1:0] s;
        s = v >> k;
        return s[0];
    endfunction

    function automatic logic [4:0] msg_of(input logic [MW-1:0] v, input int k);
        logic [MW-1:0] s;
        s = v >> (5 * k);
        return s[4:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Serial engine stand-in: collects 8 bits while enabled, clears when disabled
    logic [7:0] e_sh [2];
    logic [3:0] e_n  [2];
    logic [1:0] e_en, e_dat;
    assign e_en  = {en2, en1};
    assign e_dat = {dat2, dat1};

    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (!e_en[j]) begin
                e_sh[j] <= 8'h00;
                e_n[j]  <= 4'd0;
            end else if (e_n[j] < 4'd8) begin
                e_sh[j] <= {e_sh[j][6:0], e_dat[j]};
                e_n[j]  <= e_n[j] + 4'd1;
            end
        end
    end

    function automatic logic [7:0] eng_out(input logic [7:0] sh, input logic [3:0] n, input bit inj);
        if (n < 4'd8) return sh;
        if (inj && sh[7:3] == 5'b10000) return 8'h85;
        return codeword(sh[7:3]);
    endfunction

    assign eres1 = eng_out(e_sh[0], e_n[0], inject);
    assign eres2 = eng_out(e_sh[1], e_n[1], inject);

    int           cyc = 0;
    int           free_at = 0;
    int           acc_cyc = -100;
    int           rr_m = 0;
    logic [4:0]   acc_msg = 5'd0;
    bit           acc_bad = 1'b0;
    bit           err_m = 1'b0;
    logic [N-1:0] acc_seen = '0;

    // Reference model: a job occupies 11 cycles; grants rotate from the last winner + 1
    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        int           gid;
        int           k_feed;
        logic         en_exp;
        logic         dat_exp;
        logic [4:0]   m;
        bit           bad;
        if (reset) begin
            free_at  = cyc;
            rr_m     = 0;
            acc_cyc  = -100;
            err_m    = 1'b0;
            acc_seen = '0;
            sb.delete();
        end else begin
            gid = -1;
            if (cyc >= free_at) begin
                for (int k = N - 1; k >= 0; k--)
                    if (bit_of(req_valid, (rr_m + k) % N)) gid = (rr_m + k) % N;
            end
            exp_ready = (gid >= 0) ? (N'(1) << gid) : '0;
            check("req_ready", 32'(ready1), 32'(exp_ready));
            check("busy", 32'(busy1), 32'(cyc < free_at));
            k_feed  = cyc - acc_cyc - 1;
            en_exp  = (cyc > acc_cyc) && (cyc <= acc_cyc + 9);
            dat_exp = (en_exp && k_feed < 5) ? acc_msg[4 - k_feed] : 1'b0;
            check("eng_enable", 32'(en1), 32'(en_exp));
            check("eng_data", 32'(dat1), 32'(dat_exp));
            check("err", 32'(err1), 32'(err_m));
            check("err_check_disabled", 32'(err2), 32'd0);
            acc_seen = req_valid & ready1;
            if (cyc == acc_cyc + 9 && acc_bad) err_m = 1'b1;
            else if (err_clr) err_m = 1'b0;
            if (gid >= 0) begin
                m   = msg_of(req_msg, gid);
                bad = inject && (m == 5'b10000);
                sb.push_back('{id: IDW'(gid), data: (bad ? 8'h85 : codeword(m)),
                               due: $time + 10 * PERIOD});
                rr_m    = (gid + 1) % N;
                free_at = cyc + 11;
                acc_cyc = cyc;
                acc_msg = m;
                acc_bad = bad;
            end
        end
        cyc++;
    end

    // Monitor: every res_valid pulse must match the oldest expected job, on time
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            check("res_valid_in_reset", 32'(rv1), 32'd0);
        end else if (rv1) begin
            if (sb.size() == 0) begin
                check("res_valid_unexpected", 32'(rv1), 32'd0);
            end else begin
                e = sb.pop_front();
                check("res_data", 32'(rd1), 32'(e.data));
                check("res_id", 32'(rid1), 32'(e.id));
                check("res_time", 32'($time), 32'(e.due));
                check("nochk_res_valid", 32'(rv2), 32'd1);
                check("nochk_res_data", 32'(rd2), 32'(e.data));
            end
        end else begin
            check("nochk_res_valid_idle", 32'(rv2), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [4:0] m);
        req_valid = (req_valid & ~(N'(1) << k)) | (N'(v) << k);
        req_msg   = (req_msg & ~(MW'(5'h1F) << (5 * k))) | (MW'(m) << (5 * k));
    endtask

    task automatic wait_accept(output logic [N-1:0] got);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (acc_seen == '0 && n < 40);
        got = acc_seen;
        check("accept_within_bound", 32'(acc_seen != '0), 32'd1);
    endtask

    task automatic submit(input int id, input logic [4:0] m);
        logic [N-1:0] got;
        set_req(id, 1'b1, m);
        wait_accept(got);
        check("submit_grant", 32'(got), 32'(N'(1) << id));
        set_req(id, 1'b0, m);
    endtask

    initial begin
        logic [N-1:0] got;
        reset     = 1'b1;
        req_valid = '0;
        req_msg   = '0;
        err_clr   = 1'b0;
        inject    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready1), 32'd0);
        check("reset_res_valid", 32'(rv1), 32'd0);
        check("reset_res_data", 32'(rd1), 32'd0);
        check("reset_res_id", 32'(rid1), 32'd0);
        check("reset_busy", 32'(busy1), 32'd0);
        check("reset_err", 32'(err1), 32'd0);
        check("reset_eng_enable", 32'(en1), 32'd0);
        check("reset_eng_data", 32'(dat1), 32'd0);
        reset = 1'b0;
        repeat (2) step();

        submit(0, 5'b10000);
        repeat (12) step();
        check("single_res_data", 32'(rd1), 32'h84);
        check("single_res_id", 32'(rid1), 32'd0);

        submit(1, 5'b00000);
        repeat (12) step();
        check("zero_res_data", 32'(rd1), 32'h00);
        check("zero_res_id", 32'(rid1), 32'd1);
        check("zero_err", 32'(err1), 32'd0);

        // Fairness: every requester continuously valid, refilled after each accept
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 5'($urandom_range(0, 31)));
        for (int t = 0; t < 60; t++) begin
            step();
            for (int k = 0; k < N; k++)
                if (bit_of(acc_seen, k)) set_req(k, 1'b1, 5'($urandom_range(0, 31)));
        end
        req_valid = '0;
        repeat (12) step();

        // Wrap: grant to 3, then 0 and 3 both valid must pick 0
        submit(3, 5'b01011);
        set_req(0, 1'b1, 5'b11001);
        set_req(3, 1'b1, 5'b00111);
        wait_accept(got);
        check("wrap_grant", 32'(got), 32'b0001);
        set_req(0, 1'b0, 5'b11001);
        wait_accept(got);
        check("wrap_second_grant", 32'(got), 32'b1000);
        req_valid = '0;
        repeat (12) step();

        // Engine fault: sticky err, clear, then new error beating a held clear
        inject = 1'b1;
        submit(0, 5'b10000);
        repeat (12) step();
        check("err_set", 32'(err1), 32'd1);
        check("err_data", 32'(rd1), 32'h85);
        repeat (5) step();
        check("err_sticky", 32'(err1), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_cleared", 32'(err1), 32'd0);
        err_clr = 1'b1;
        submit(0, 5'b10000);
        repeat (12) step();
        err_clr = 1'b0;
        inject  = 1'b0;
        repeat (2) step();

        // Reset in the middle of FEED (cnt = 4)
        submit(2, 5'b10110);
        repeat (4) step();
        check("pre_reset_enable", 32'(en1), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_mid_enable", 32'(en1), 32'd0);
        check("reset_mid_busy", 32'(busy1), 32'd0);
        check("reset_mid_res_valid", 32'(rv1), 32'd0);
        step();
        step();
        reset = 1'b0;
        repeat (15) step();
        submit(2, 5'b10110);
        repeat (12) step();
        check("post_reset_res_data", 32'(rd1), 32'(codeword(5'b10110)));

        // Random traffic with occasional err_clr pulses
        for (int t = 0; t < 500; t++) begin
            step();
            err_clr = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < N; k++) begin
                if (bit_of(acc_seen, k)) begin
                    set_req(k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
                end else if (bit_of(req_valid, k)) begin
                    if ($urandom_range(0, 15) == 0) set_req(k, 1'b0, msg_of(req_msg, k));
                end else if ($urandom_range(0, 3) == 0) begin
                    set_req(k, 1'b1, 5'($urandom_range(0, 31)));
                end
            end
        end
        req_valid = '0;
        err_clr   = 1'b0;
        repeat (15) step();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
